// File: rtl/pong_frame_renderer.sv
// Pong pixel source: owns per-frame ball/paddle/score state and returns registered RGB
// exactly PIPELINE_STAGES cycles after the connector presents a column.
module pong_frame_renderer #(
  parameter int unsigned WIDTH           = 640,
  parameter int unsigned HEIGHT          = 480,
  parameter int unsigned H_CNT_WID       = 10,
  parameter int unsigned V_CNT_WID       = 10,
  parameter int unsigned PIPELINE_STAGES = 2,
  parameter int unsigned PADDLE_W        = 8,
  parameter int unsigned PADDLE_H        = 64,
  parameter int unsigned PADDLE_X_OFF    = 16,
  parameter int unsigned BALL_SIZE       = 8,
  parameter int unsigned BALL_SPEED      = 2,
  parameter int unsigned SERVE_FRAMES    = 60
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 pixIf_NEXT_FRAME,
  input  logic                 pixIf_H_BLANKING,
  input  logic [H_CNT_WID-1:0] pixIf_H_CNT,
  input  logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
  output logic [3:0]           pixIf_r,
  output logic [3:0]           pixIf_g,
  output logic [3:0]           pixIf_b,
  input  logic [V_CNT_WID-1:0] paddle_l_y,
  input  logic [V_CNT_WID-1:0] paddle_r_y,
  output logic [3:0]           score_l,
  output logic [3:0]           score_r,
  output logic [1:0]           game_state
);

  if (PIPELINE_STAGES < 1) begin : g_bad_stages
    $error("PIPELINE_STAGES must be at least 1");
  end

  localparam int unsigned HW  = H_CNT_WID + 1;
  localparam int unsigned VW  = V_CNT_WID + 1;
  localparam int unsigned SCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam int unsigned FaceL = PADDLE_X_OFF + PADDLE_W;
  localparam int unsigned FaceR = WIDTH - PADDLE_X_OFF - PADDLE_W;

  typedef logic signed [HW-1:0] sh_t;
  typedef logic signed [VW-1:0] sv_t;
  typedef enum logic [1:0] {
    StServe = 2'd0,
    StPlay  = 2'd1,
    StScore = 2'd2
  } state_e;

  localparam sh_t BallXC   = sh_t'((WIDTH - BALL_SIZE) / 2);
  localparam sv_t BallYC   = sv_t'((HEIGHT - BALL_SIZE) / 2);
  localparam sv_t BallYMax = sv_t'(HEIGHT - BALL_SIZE);
  localparam sh_t BallH    = sh_t'(BALL_SIZE);
  localparam sv_t BallV    = sv_t'(BALL_SIZE);
  localparam sh_t SpdH     = sh_t'(BALL_SPEED);
  localparam sh_t SpdHNeg  = -sh_t'(BALL_SPEED);
  localparam sv_t SpdV     = sv_t'(BALL_SPEED);
  localparam sv_t SpdVNeg  = -sv_t'(BALL_SPEED);
  localparam sh_t ZeroH    = sh_t'(0);
  localparam sv_t ZeroV    = sv_t'(0);
  localparam sh_t FaceLH   = sh_t'(FaceL);
  localparam sh_t FaceRH   = sh_t'(FaceR);
  localparam sh_t WidthH   = sh_t'(WIDTH);
  localparam sv_t PadHV    = sv_t'(PADDLE_H);

  localparam logic [V_CNT_WID-1:0] PadMax  = V_CNT_WID'(HEIGHT - PADDLE_H);
  localparam logic [V_CNT_WID-1:0] HeightV = V_CNT_WID'(HEIGHT);
  localparam logic [H_CNT_WID-1:0] PadLX0  = H_CNT_WID'(PADDLE_X_OFF);
  localparam logic [H_CNT_WID-1:0] PadLX1  = H_CNT_WID'(FaceL);
  localparam logic [H_CNT_WID-1:0] PadRX0  = H_CNT_WID'(FaceR);
  localparam logic [H_CNT_WID-1:0] PadRX1  = H_CNT_WID'(FaceR + PADDLE_W);
  localparam logic [H_CNT_WID-1:0] NetX0   = H_CNT_WID'(WIDTH / 2 - 1);
  localparam logic [H_CNT_WID-1:0] NetX1   = H_CNT_WID'(WIDTH / 2);
  localparam logic [SCW-1:0]       ServeLast = SCW'(SERVE_FRAMES - 1);

  state_e               state_q;
  logic [SCW-1:0]       serve_cnt_q;
  logic [3:0]           score_l_q, score_r_q;
  sh_t                  bx_q, vx_q;
  sv_t                  by_q, vy_q;
  logic [V_CNT_WID-1:0] pl_q, pr_q;

  logic hb_q, row_eval_q;
  logic ball_row_q, lpad_row_q, rpad_row_q, net_row_q;
  logic [11:0] pipe_q [PIPELINE_STAGES];

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // ---------------------------------------------------------------- frame update
  logic [V_CNT_WID-1:0] pl_clamp, pr_clamp;
  sh_t                  nx;
  sv_t                  ny, pl_s, pr_s;
  logic                 ov_l, ov_r;

  always_comb begin
    pl_clamp = (paddle_l_y > PadMax) ? PadMax : paddle_l_y;
    pr_clamp = (paddle_r_y > PadMax) ? PadMax : paddle_r_y;
    pl_s     = $signed({1'b0, pl_clamp});
    pr_s     = $signed({1'b0, pr_clamp});
    nx       = bx_q + vx_q;
    ny       = by_q + vy_q;
    // Overlap uses the pre-move row so the paddle test matches what was last drawn.
    ov_l     = (by_q + BallV > pl_s) && (by_q < pl_s + PadHV);
    ov_r     = (by_q + BallV > pr_s) && (by_q < pr_s + PadHV);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StServe;
      serve_cnt_q <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      bx_q        <= BallXC;
      by_q        <= BallYC;
      vx_q        <= SpdH;
      vy_q        <= SpdV;
      pl_q        <= '0;
      pr_q        <= '0;
    end else if (pixIf_NEXT_FRAME) begin
      pl_q <= pl_clamp;
      pr_q <= pr_clamp;
      case (state_q)
        StPlay: begin
          if (ny <= ZeroV) begin
            by_q <= ZeroV;
            vy_q <= SpdV;
          end else if (ny >= BallYMax) begin
            by_q <= BallYMax;
            vy_q <= SpdVNeg;
          end else begin
            by_q <= ny;
          end
          if (vx_q < ZeroH) begin
            if (nx <= FaceLH && ov_l) begin
              bx_q <= FaceLH;
              vx_q <= SpdH;
            end else if (nx <= ZeroH) begin
              bx_q      <= nx;
              vx_q      <= SpdHNeg;
              score_r_q <= sat_inc(score_r_q);
              state_q   <= StScore;
            end else begin
              bx_q <= nx;
            end
          end else begin
            if (nx + BallH >= FaceRH && ov_r) begin
              bx_q <= FaceRH - BallH;
              vx_q <= SpdHNeg;
            end else if (nx + BallH >= WidthH) begin
              bx_q      <= nx;
              vx_q      <= SpdH;
              score_l_q <= sat_inc(score_l_q);
              state_q   <= StScore;
            end else begin
              bx_q <= nx;
            end
          end
        end
        StScore: begin
          bx_q        <= BallXC;
          by_q        <= BallYC;
          vy_q        <= SpdV;
          serve_cnt_q <= '0;
          state_q     <= StServe;
        end
        default: begin
          // Also covers the unreachable code 3.
          bx_q <= BallXC;
          by_q <= BallYC;
          if (serve_cnt_q == ServeLast) begin
            serve_cnt_q <= '0;
            state_q     <= StPlay;
          end else begin
            serve_cnt_q <= serve_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign game_state = state_q;

  // ---------------------------------------------------------------- row stage
  sv_t  row_s, plr_s, prr_s;
  logic row_vis, ball_row_d, lpad_row_d, rpad_row_d;

  always_comb begin
    row_s      = $signed({1'b0, pixIf_next_V_CNT});
    plr_s      = $signed({1'b0, pl_q});
    prr_s      = $signed({1'b0, pr_q});
    row_vis    = pixIf_next_V_CNT < HeightV;
    ball_row_d = (row_s >= by_q) && (row_s < by_q + BallV);
    lpad_row_d = (row_s >= plr_s) && (row_s < plr_s + PadHV);
    rpad_row_d = (row_s >= prr_s) && (row_s < prr_s + PadHV);
  end

  // Evaluate one cycle after the blanking edge so a same-cycle frame update is seen.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hb_q       <= 1'b0;
      row_eval_q <= 1'b0;
      ball_row_q <= 1'b0;
      lpad_row_q <= 1'b0;
      rpad_row_q <= 1'b0;
      net_row_q  <= 1'b0;
    end else begin
      hb_q       <= pixIf_H_BLANKING;
      row_eval_q <= pixIf_H_BLANKING & ~hb_q;
      if (row_eval_q) begin
        ball_row_q <= row_vis & ball_row_d;
        lpad_row_q <= row_vis & lpad_row_d;
        rpad_row_q <= row_vis & rpad_row_d;
        net_row_q  <= row_vis & ~pixIf_next_V_CNT[3];
      end
    end
  end

  // ---------------------------------------------------------------- column / colour
  sh_t         col_s;
  logic        ball_col, lpad_col, rpad_col, net_col;
  logic [11:0] colour;

  always_comb begin
    col_s    = $signed({1'b0, pixIf_H_CNT});
    ball_col = (col_s >= bx_q) && (col_s < bx_q + BallH);
    lpad_col = (pixIf_H_CNT >= PadLX0) && (pixIf_H_CNT < PadLX1);
    rpad_col = (pixIf_H_CNT >= PadRX0) && (pixIf_H_CNT < PadRX1);
    net_col  = (pixIf_H_CNT == NetX0) || (pixIf_H_CNT == NetX1);
    colour   = 12'h000;
    if (ball_row_q && ball_col) begin
      colour = 12'hFFF;
    end else if ((lpad_row_q && lpad_col) || (rpad_row_q && rpad_col)) begin
      colour = 12'hFFF;
    end else if (net_row_q && net_col) begin
      colour = 12'h888;
    end
  end

  // Blanking travels with the pixel; masking at entry equals masking at the output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(PIPELINE_STAGES); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pixIf_H_BLANKING ? 12'h000 : colour;
      for (int i = 1; i < int'(PIPELINE_STAGES); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {pixIf_r, pixIf_g, pixIf_b} = pipe_q[PIPELINE_STAGES-1];

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer using an abbreviated connector-timing model
// (short lines, one NEXT_FRAME pulse per frame).
module tb_pong_frame_renderer;
  logic       clk = 1'b0;
  logic       rst, nf, hb;
  logic [9:0] hcnt, vnext, pl_y, pr_y, pr_y_s1;
  logic [3:0] r, g, b, sl, sr;
  logic [3:0] r1, g1, b1, sl1, sr1;
  logic [1:0] gs, gs1;
  logic [11:0] rgb, rgb1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rgb  = {r, g, b};
  assign rgb1 = {r1, g1, b1};

  pong_frame_renderer dut (
    .CLK(clk), .RST(rst), .pixIf_NEXT_FRAME(nf), .pixIf_H_BLANKING(hb),
    .pixIf_H_CNT(hcnt), .pixIf_next_V_CNT(vnext),
    .pixIf_r(r), .pixIf_g(g), .pixIf_b(b),
    .paddle_l_y(pl_y), .paddle_r_y(pr_y),
    .score_l(sl), .score_r(sr), .game_state(gs)
  );

  pong_frame_renderer #(.SERVE_FRAMES(1)) dut_s1 (
    .CLK(clk), .RST(rst), .pixIf_NEXT_FRAME(nf), .pixIf_H_BLANKING(hb),
    .pixIf_H_CNT(hcnt), .pixIf_next_V_CNT(vnext),
    .pixIf_r(r1), .pixIf_g(g1), .pixIf_b(b1),
    .paddle_l_y(pl_y), .paddle_r_y(pr_y_s1),
    .score_l(sl1), .score_r(sr1), .game_state(gs1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; nf = 1'b0; hb = 1'b1; hcnt = 10'd640; vnext = 10'd0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  // One frame: blanking edge coincident with the NEXT_FRAME pulse, row 0 next.
  task automatic frame;
    hb = 1'b0; hcnt = 10'd0;
    tick; tick;
    hb = 1'b1; hcnt = 10'd640; vnext = 10'd0; nf = 1'b1;
    tick;
    nf = 1'b0;
    tick; tick;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  // Blanking interval announcing the row, then back into the visible area.
  task automatic line(input int row);
    hb = 1'b0; hcnt = 10'd0;
    tick; tick;
    hb = 1'b1; hcnt = 10'd640; vnext = 10'(row);
    tick; tick; tick;
    hb = 1'b0; hcnt = 10'd0;
    tick; tick;
  endtask

  task automatic drive_pix(input int col, output logic [11:0] got, output logic [11:0] got1);
    hcnt = 10'(col);
    tick; tick;
    got  = rgb;
    got1 = rgb1;
    hcnt = 10'd0;
    tick; tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; nf = 1'b0; hb = 1'b1; hcnt = 10'd640; vnext = 10'd0;
    tick; tick;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", gs); end
    checks++; if (sl !== 4'd0) begin errors++; $display("FAIL reset_score_l: got %0d want 0", sl); end
    checks++; if (sr !== 4'd0) begin errors++; $display("FAIL reset_score_r: got %0d want 0", sr); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_render;
    int          cols[6] = '{320, 323, 324, 316, 315, 319};
    logic [11:0] exps[6] = '{12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    logic [11:0] got, got1;
    apply_reset();
    frame();
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL t1_state: got %0d want 0", gs); end
    line(240);
    // Exact two-cycle latency from column to colour.
    hcnt = 10'd320;
    tick;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL t1_latency1: got %h want 000", rgb); end
    tick;
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL t1_latency2: got %h want fff", rgb); end
    hcnt = 10'd0; tick; tick;
    for (int i = 0; i < 6; i++) begin
      drive_pix(cols[i], got, got1);
      checks++;
      if (got !== exps[i]) begin
        errors++; $display("FAIL t1_row240_col%0d: got %h want %h", cols[i], got, exps[i]);
      end
    end
    // Blanked pixels are black even inside the ball.
    hb = 1'b1; hcnt = 10'd320;
    tick; tick;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL t1_blank: got %h want 000", rgb); end
    line(224);
    drive_pix(319, got, got1);
    checks++; if (got !== 12'h888) begin errors++; $display("FAIL t1_net319: got %h want 888", got); end
    drive_pix(320, got, got1);
    checks++; if (got !== 12'h888) begin errors++; $display("FAIL t1_net320: got %h want 888", got); end
    drive_pix(321, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t1_net321: got %h want 000", got); end
    line(248);
    drive_pix(319, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t1_netgap248: got %h want 000", got); end
    line(480);
    drive_pix(320, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t1_row480: got %h want 000", got); end
  endtask

  task automatic test_paddles;
    logic [11:0] got, got1;
    apply_reset();
    pl_y = 10'd470; pr_y = 10'd0;
    frame();
    line(479);
    drive_pix(20, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL pad_l_clamp479: got %h want fff", got); end
    line(415);
    drive_pix(20, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL pad_l_clamp415: got %h want 000", got); end
    line(10);
    drive_pix(616, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL pad_r616: got %h want fff", got); end
    drive_pix(623, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL pad_r623: got %h want fff", got); end
    drive_pix(624, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL pad_r624: got %h want 000", got); end
    drive_pix(615, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL pad_r615: got %h want 000", got); end
    pl_y = 10'd100;
  endtask

  task automatic test_serve_to_play;
    logic [11:0] got, got1;
    apply_reset();
    frames(59);
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL t2_serve59: got %0d want 0", gs); end
    frame();
    checks++; if (gs !== 2'd1) begin errors++; $display("FAIL t2_play60: got %0d want 1", gs); end
    frame();
    line(238);
    drive_pix(318, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t2_c318: got %h want fff", got); end
    drive_pix(325, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t2_c325: got %h want fff", got); end
    drive_pix(326, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t2_c326: got %h want 000", got); end
    drive_pix(317, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t2_c317: got %h want 000", got); end
    line(237);
    drive_pix(322, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t2_r237: got %h want 000", got); end
    line(245);
    drive_pix(322, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t2_r245: got %h want fff", got); end
    line(246);
    drive_pix(322, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t2_r246: got %h want 000", got); end
  endtask

  // SERVE_FRAMES=1: ball reaches bx=606,by=418 after 146 pulses; hit on pulse 147.
  task automatic test_right_bounce;
    logic [11:0] got, got1;
    pr_y_s1 = 10'd390;
    apply_reset();
    frames(146);
    line(420);
    drive_pix(606, got, got1);
    checks++; if (got1 !== 12'hFFF) begin errors++; $display("FAIL t3_pre606: got %h want fff", got1); end
    frame();
    line(420);
    drive_pix(606, got, got1);
    checks++; if (got1 !== 12'h000) begin errors++; $display("FAIL t3_hit606: got %h want 000", got1); end
    drive_pix(607, got, got1);
    checks++; if (got1 !== 12'h000) begin errors++; $display("FAIL t3_hit607: got %h want 000", got1); end
    drive_pix(608, got, got1);
    checks++; if (got1 !== 12'hFFF) begin errors++; $display("FAIL t3_hit608: got %h want fff", got1); end
    drive_pix(615, got, got1);
    checks++; if (got1 !== 12'hFFF) begin errors++; $display("FAIL t3_hit615: got %h want fff", got1); end
    checks++; if (gs1 !== 2'd1) begin errors++; $display("FAIL t3_state: got %0d want 1", gs1); end
    frame();
    line(420);
    drive_pix(606, got, got1);
    checks++; if (got1 !== 12'hFFF) begin errors++; $display("FAIL t3_back606: got %h want fff", got1); end
    checks++; if (sl1 !== 4'd0) begin errors++; $display("FAIL t3_score_l: got %0d want 0", sl1); end
    checks++; if (sr1 !== 4'd0) begin errors++; $display("FAIL t3_score_r: got %0d want 0", sr1); end
  endtask

  // Default timing: 60 serve pulses, right-wall miss on play pulse 158 (pulse 218).
  task automatic test_right_miss;
    logic [11:0] got, got1;
    pr_y = 10'd0;
    apply_reset();
    frames(217);
    checks++; if (gs !== 2'd1) begin errors++; $display("FAIL t4_pre_state: got %0d want 1", gs); end
    checks++; if (sl !== 4'd0) begin errors++; $display("FAIL t4_pre_score: got %0d want 0", sl); end
    frame();
    checks++; if (gs !== 2'd2) begin errors++; $display("FAIL t4_score_state: got %0d want 2", gs); end
    checks++; if (sl !== 4'd1) begin errors++; $display("FAIL t4_score_l: got %0d want 1", sl); end
    checks++; if (sr !== 4'd0) begin errors++; $display("FAIL t4_score_r: got %0d want 0", sr); end
    frame();
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL t4_serve_state: got %0d want 0", gs); end
    line(240);
    drive_pix(316, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t4_centre316: got %h want fff", got); end
    drive_pix(315, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t4_centre315: got %h want 000", got); end
    frames(61);
    checks++; if (gs !== 2'd1) begin errors++; $display("FAIL t4_replay_state: got %0d want 1", gs); end
    line(240);
    drive_pix(324, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t4_vx_pos324: got %h want fff", got); end
    drive_pix(317, got, got1);
    checks++; if (got !== 12'h000) begin errors++; $display("FAIL t4_vx_pos317: got %h want 000", got); end
  endtask

  task automatic test_score_saturation;
    int want;
    pr_y = 10'd0;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      frames(219);
      want = (i > 15) ? 15 : i;
      checks++;
      if (sl !== 4'(want)) begin
        errors++; $display("FAIL t5_round%0d: got %0d want %0d", i, sl, want);
      end
    end
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL t5_state: got %0d want 0", gs); end
  endtask

  task automatic test_reset_mid_play;
    logic [11:0] got, got1;
    frames(61);
    checks++; if (gs !== 2'd1) begin errors++; $display("FAIL t6_play: got %0d want 1", gs); end
    line(240);
    hcnt = 10'd320;
    tick; tick;
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL t6_pre_rgb: got %h want fff", rgb); end
    rst = 1'b1;
    tick;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL t6_rst_rgb: got %h want 000", rgb); end
    checks++; if (gs !== 2'd0) begin errors++; $display("FAIL t6_rst_state: got %0d want 0", gs); end
    checks++; if (sl !== 4'd0) begin errors++; $display("FAIL t6_rst_score_l: got %0d want 0", sl); end
    rst = 1'b0;
    tick; tick; tick;
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL t6_first_row: got %h want 000", rgb); end
    hcnt = 10'd0;
    line(240);
    drive_pix(320, got, got1);
    checks++; if (got !== 12'hFFF) begin errors++; $display("FAIL t6_recentred: got %h want fff", got); end
  endtask

  initial begin
    rst = 1'b1; nf = 1'b0; hb = 1'b1; hcnt = 10'd640; vnext = 10'd0;
    pl_y = 10'd100; pr_y = 10'd0; pr_y_s1 = 10'd390;
    test_reset();
    test_render();
    test_paddles();
    test_serve_to_play();
    test_right_bounce();
    test_right_miss();
    test_score_saturation();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
